// File: rtl/mac_learn_scheduler.sv
// Source-MAC learn scheduler: per-port pending/last-written filtering feeding a
// round-robin single-write table port with a valid/ready handshake.

module mac_learn_lane #(
  parameter int MAC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             learn_valid,
  input  logic [MAC_W-1:0] learn_mac,
  input  logic             load,
  input  logic             wr_done,
  input  logic [MAC_W-1:0] wr_mac,
  output logic             pend_vld,
  output logic [MAC_W-1:0] pend_mac,
  output logic             overflow
);
  logic             lw_vld;
  logic [MAC_W-1:0] lw_mac;
  logic             accept;

  // Group bit is the LSB of the first wire byte.
  assign accept = learn_valid && !learn_mac[MAC_W-8] && (learn_mac != '0) &&
                  !(lw_vld && (learn_mac == lw_mac));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_mac <= '0;
      lw_vld   <= 1'b0;
      lw_mac   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= accept && pend_vld && !load;
      if (accept) begin
        pend_vld <= 1'b1;
        pend_mac <= learn_mac;
      end else if (load) begin
        pend_vld <= 1'b0;
      end
      if (wr_done) begin
        lw_vld <= 1'b1;
        lw_mac <= wr_mac;
      end
    end
  end
endmodule

module mac_learn_scheduler #(
  parameter  int NUM_PORTS = 4,
  parameter  int MAC_W     = 48,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            learn_valid_in,
  input  logic [NUM_PORTS-1:0][MAC_W-1:0] learn_mac_in,
  output logic                            wr_valid,
  output logic [MAC_W-1:0]                wr_mac,
  output logic [PW-1:0]                   wr_port,
  input  logic                            wr_ready,
  output logic [NUM_PORTS-1:0]            overflow,
  output logic                            busy
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t                          state_q, state_d;
  logic [NUM_PORTS-1:0]            pend_vld, load, wr_done;
  logic [NUM_PORTS-1:0][MAC_W-1:0] pend_mac;
  logic [PW-1:0]                   last_grant, sel, idx;
  logic                            sel_found, grant_en, hs;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign wr_done[i] = hs && (wr_port == PW'(i));
    mac_learn_lane #(.MAC_W(MAC_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .learn_valid(learn_valid_in[i]),
      .learn_mac  (learn_mac_in[i]),
      .load       (load[i]),
      .wr_done    (wr_done[i]),
      .wr_mac     (wr_mac),
      .pend_vld   (pend_vld[i]),
      .pend_mac   (pend_mac[i]),
      .overflow   (overflow[i])
    );
  end

  // Scan offsets from farthest to nearest so the nearest pending port after last_grant wins.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (pend_vld[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = '0;
    grant_en = 1'b0;
    hs       = 1'b0;
    case (state_q)
      IDLE: if (sel_found) begin
        grant_en  = 1'b1;
        load[sel] = 1'b1;
        state_d   = OFFER;
      end
      OFFER: if (wr_ready) begin
        hs      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_mac     <= '0;
      wr_port    <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        wr_mac     <= pend_mac[sel];
        wr_port    <= sel;
        last_grant <= sel;
      end
    end
  end

  assign wr_valid = (state_q == OFFER);
  assign busy     = (|pend_vld) || wr_valid;
endmodule

// File: tb/tb_mac_learn_scheduler.sv
// Directed scenarios plus random traffic against a transaction-level model of the learn scheduler.

module tb_mac_learn_scheduler;
  localparam int NP = 4;
  localparam int MW = 48;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          learn_valid_in;
  logic [NP-1:0][MW-1:0]  learn_mac_in;
  logic                   wr_valid;
  logic [MW-1:0]          wr_mac;
  logic [1:0]             wr_port;
  logic                   wr_ready;
  logic [NP-1:0]          overflow;
  logic                   busy;

  always #5 clk = ~clk;

  mac_learn_scheduler #(.NUM_PORTS(NP), .MAC_W(MW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .learn_valid_in(learn_valid_in),
    .learn_mac_in  (learn_mac_in),
    .wr_valid      (wr_valid),
    .wr_mac        (wr_mac),
    .wr_port       (wr_port),
    .wr_ready      (wr_ready),
    .overflow      (overflow),
    .busy          (busy)
  );

  int nvec = 0;
  int nerr = 0;

  // reference model state
  bit          m_pv[NP];
  logic [MW-1:0] m_pm[NP];
  bit          m_lv[NP];
  logic [MW-1:0] m_lm[NP];
  bit          m_off;
  logic [MW-1:0] m_wm;
  int          m_wp;
  int          m_lg;
  logic [NP-1:0] m_ovf;

  int            log_port[$];
  logic [MW-1:0] log_mac[$];

  localparam logic [MW-1:0] MAC_A = 48'h0200_0000_00A1;
  localparam logic [MW-1:0] MAC_B = 48'h0200_0000_00B2;
  localparam logic [MW-1:0] MAC_C = 48'h0200_0000_00C3;
  localparam logic [MW-1:0] MAC_D = 48'h0A0B_0C0D_0E0F;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_pv[p] = 1'b0; m_pm[p] = '0; m_lv[p] = 1'b0; m_lm[p] = '0;
    end
    m_off = 1'b0; m_wm = '0; m_wp = 0; m_lg = NP - 1; m_ovf = '0;
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_step();
    int            ld;
    logic [MW-1:0] lmac;
    bit            hs, acc;
    ld = -1;
    lmac = '0;
    if (!m_off)
      for (int k = 1; k <= NP; k++)
        if (ld < 0 && m_pv[(m_lg + k) % NP]) ld = (m_lg + k) % NP;
    if (ld >= 0) lmac = m_pm[ld];
    hs = m_off && wr_ready;
    for (int p = 0; p < NP; p++) begin
      acc = learn_valid_in[p] && !learn_mac_in[p][40] && (learn_mac_in[p] != '0) &&
            !(m_lv[p] && learn_mac_in[p] == m_lm[p]);
      m_ovf[p] = acc && m_pv[p] && (ld != p);
      if (acc) begin
        m_pv[p] = 1'b1; m_pm[p] = learn_mac_in[p];
      end else if (ld == p) begin
        m_pv[p] = 1'b0;
      end
    end
    if (hs) begin m_lv[m_wp] = 1'b1; m_lm[m_wp] = m_wm; end
    if (ld >= 0) begin m_wm = lmac; m_wp = ld; m_lg = ld; m_off = 1'b1; end
    else if (hs) m_off = 1'b0;
  endtask

  task automatic check_all();
    bit mb;
    mb = m_off;
    for (int p = 0; p < NP; p++) mb = mb | m_pv[p];
    chk("wr_valid", 64'(wr_valid), 64'(m_off));
    chk("wr_mac",   64'(wr_mac),   64'(m_wm));
    chk("wr_port",  64'(wr_port),  64'(m_wp));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("busy",     64'(busy),     64'(mb));
  endtask

  task automatic tick();
    if (wr_valid && wr_ready) begin
      log_port.push_back(int'(wr_port));
      log_mac.push_back(wr_mac);
    end
    model_step();
    @(posedge clk);
    #1;
    learn_valid_in = '0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int p, input logic [MW-1:0] mac);
    learn_valid_in[p] = 1'b1;
    learn_mac_in[p]   = mac;
  endtask

  task automatic do_reset();
    learn_valid_in = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_port.delete();
    log_mac.delete();
  endtask

  initial begin
    logic [MW-1:0] pool[6];
    rst_n          = 1'b0;
    learn_valid_in = '0;
    learn_mac_in   = '0;
    wr_ready       = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single learn, latency and idle after handshake
    wr_ready = 1'b1;
    pulse(2, 48'h0011_2233_4455);
    tick();
    chk("lat_t1_valid", 64'(wr_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(wr_valid), 64'd1);
    chk("lat_t2_mac",   64'(wr_mac), 64'h0011_2233_4455);
    chk("lat_t2_port",  64'(wr_port), 64'd2);
    tick();
    chk("busy_after_hs", 64'(busy), 64'd0);

    // all ports at once after reset
    do_reset();
    for (int p = 0; p < NP; p++) pulse(p, MAC_D + 48'(p));
    ticks(10);
    chk("rr_nwrites", 64'(log_port.size()), 64'd4);
    for (int i = 0; i < NP; i++)
      if (i < log_port.size()) begin
        chk("rr_port", 64'(log_port[i]), 64'(i));
        chk("rr_mac",  64'(log_mac[i]),  64'(MAC_D + 48'(i)));
      end

    // group and zero addresses are dropped
    log_port.delete(); log_mac.delete();
    pulse(0, 48'h0100_5E00_0001);
    tick();
    pulse(0, 48'h0);
    ticks(4);
    chk("filt_busy", 64'(busy), 64'd0);
    chk("filt_nwrites", 64'(log_port.size()), 64'd0);

    // last-written filter on port 1
    pulse(1, MAC_A); ticks(4);
    pulse(1, MAC_A); ticks(4);
    pulse(1, MAC_B); ticks(4);
    pulse(1, MAC_A); ticks(4);
    chk("lw_nwrites", 64'(log_mac.size()), 64'd3);
    if (log_mac.size() == 3) begin
      chk("lw_w0", 64'(log_mac[0]), 64'(MAC_A));
      chk("lw_w1", 64'(log_mac[1]), 64'(MAC_B));
      chk("lw_w2", 64'(log_mac[2]), 64'(MAC_A));
    end

    // back-pressure with overwrite of the pending entry
    do_reset();
    wr_ready = 1'b0;
    pulse(0, MAC_A); tick();
    pulse(0, MAC_B); tick();
    chk("ovf_b_none", 64'(overflow), 64'd0);
    pulse(0, MAC_C); tick();
    chk("ovf_c_pulse", 64'(overflow), 64'b0001);
    ticks(3);
    chk("ovf_hold_mac", 64'(wr_mac), 64'(MAC_A));
    chk("ovf_hold_vld", 64'(wr_valid), 64'd1);
    wr_ready = 1'b1;
    ticks(6);
    chk("ovf_nwrites", 64'(log_mac.size()), 64'd2);
    if (log_mac.size() == 2) begin
      chk("ovf_w0", 64'(log_mac[0]), 64'(MAC_A));
      chk("ovf_w1", 64'(log_mac[1]), 64'(MAC_C));
    end

    // reset in the middle of an offer
    do_reset();
    wr_ready = 1'b0;
    pulse(3, MAC_D); ticks(2);
    chk("mid_offer_vld", 64'(wr_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_vld",  64'(wr_valid), 64'd0);
    chk("rst_mac",  64'(wr_mac), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_port.delete(); log_mac.delete();
    wr_ready = 1'b1;
    pulse(3, MAC_D); ticks(3);
    chk("rewrite_n", 64'(log_mac.size()), 64'd1);
    if (log_mac.size() == 1) begin
      chk("rewrite_mac",  64'(log_mac[0]), 64'(MAC_D));
      chk("rewrite_port", 64'(log_port[0]), 64'd3);
    end

    // random traffic
    do_reset();
    pool[0] = MAC_A; pool[1] = MAC_B; pool[2] = MAC_C; pool[3] = MAC_D;
    pool[4] = 48'h0300_0000_0001; pool[5] = '0;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(3) == 0) pulse(p, pool[$urandom_range(5)]);
      wr_ready = ($urandom_range(2) != 0);
      tick();
    end
    wr_ready = 1'b1;
    ticks(12);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mac_learn_scheduler.md
MAC_LEARN_SCHEDULER -- requirements
Module: mac_learn_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of source-MAC parser ports served.
REQ-002 The block SHALL have parameter MAC_W, default 48, giving the MAC address width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port learn_valid_in  input  NUM_PORTS  per-port one-cycle pulse: source MAC detected.
REQ-006 The block SHALL have port learn_mac_in  input  NUM_PORTS x MAC_W  per-port source MAC, first wire byte in bits [47:40], sampled when learn_valid_in is 1.
REQ-007 The block SHALL have port wr_valid  output  1  table-write request.
REQ-008 The block SHALL have port wr_mac  output  MAC_W  MAC to write to the table.
REQ-009 The block SHALL have port wr_port  output  clog2(NUM_PORTS)  port on which wr_mac was learned.
REQ-010 The block SHALL have port wr_ready  input  1  table accepts the write.
REQ-011 The block SHALL have port overflow  output  NUM_PORTS  per-port one-cycle pulse: a pending entry was overwritten.
REQ-012 The block SHALL have port busy  output  1  high while any pending entry exists or wr_valid is 1.

Function
REQ-013 Each port SHALL have a one-entry pending register (valid flag plus MAC) and a last-written register (valid flag plus MAC).
REQ-014 A learn pulse SHALL be filtered out, with no state change, when mac[40] is 1 (group address) or mac is all-zero.
REQ-015 A learn pulse SHALL be filtered out when the port's last-written valid flag is 1 and mac equals the port's last-written MAC.
REQ-016 An unfiltered learn pulse at cycle t SHALL set that port's pending entry, visible at t+1.
REQ-017 If the port's pending entry is already valid and is not loaded by the arbiter in cycle t, the new MAC SHALL replace it and overflow[p] SHALL pulse at t+1.
REQ-018 If the pending entry is loaded by the arbiter in the same cycle as a new learn pulse, the new MAC SHALL be captured with no overflow.
REQ-019 The controller SHALL be a two-state FSM with states IDLE and OFFER.
REQ-020 In IDLE with any pending entry valid, the controller SHALL select one round-robin, starting from last_grant+1 modulo NUM_PORTS, load wr_mac/wr_port, clear that pending flag, update last_grant, and go to OFFER.
REQ-021 In OFFER, wr_valid SHALL be 1; wr_mac and wr_port SHALL remain stable until wr_valid and wr_ready are both 1.
REQ-022 On handshake, the controller SHALL set last-written for wr_port to wr_mac, drop wr_valid the next cycle, and return to IDLE.
REQ-023 Learn-to-request latency from an idle block SHALL be 2 cycles (pulse at t, wr_valid at t+2).
REQ-024 Sustained throughput SHALL be one write per 2 cycles when wr_ready is held at 1.
REQ-025 wr_ready while wr_valid is 0 SHALL be ignored.
REQ-026 Simultaneous pulses on all ports SHALL each be captured independently.
REQ-027 A port SHALL never wait more than NUM_PORTS grants.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, wr_valid=0, wr_mac=0, wr_port=0, overflow=0, busy=0, all pending and last-written valid flags=0, last_grant=NUM_PORTS-1.
REQ-029 Reset asserted during OFFER SHALL abort the request without a handshake; that MAC SHALL be lost, and no last-written update SHALL occur.

Verification
REQ-030 Scenario: port 2 pulses MAC 00:11:22:33:44:55 at t, wr_ready=1 -> wr_valid=1 at t+2 with wr_mac=0x001122334455 and wr_port=2; busy=0 after the handshake.
REQ-031 Scenario: all 4 ports pulse in the same cycle after reset, wr_ready=1 -> grants in order 0,1,2,3, one every 2 cycles, and no overflow.
REQ-032 Scenario: pulse MAC 01:00:5E:00:00:01, then MAC 0 -> no wr_valid and busy stays 0.
REQ-033 Scenario: port 1 writes A, then pulses A again -> filtered; port 1 then pulses B -> written; port 1 then pulses A again -> written.
REQ-034 Scenario: wr_ready=0, port 0 pulses A, B, C on consecutive cycles -> A is offered and held stable; B is overwritten by C with one overflow[0] pulse; after wr_ready=1 the writes are A then C.
REQ-035 Scenario: rst_n low mid-OFFER -> all outputs 0 immediately; a re-pulse of the same MAC after reset is written again.
